// File: rtl/spi_reg_ctrl_if.sv
// Signal bundle between the spi_reg_ctrl sequencer, the spiSlave byte port and the register bus.
// master is the sequencer side; slave is the spiSlave / register file side.
interface spi_reg_ctrl_if #(
    parameter int unsigned DATA_WDT = 8,
    parameter int unsigned ADDR_WDT = DATA_WDT - 1
);
    logic                ssel;
    logic [DATA_WDT-1:0] rxData;
    logic                rxRdy;
    logic [DATA_WDT-1:0] txData;
    logic                txLoad;
    logic [ADDR_WDT-1:0] busAddr;
    logic [DATA_WDT-1:0] busWrData;
    logic                busWr;
    logic                busRd;
    logic [DATA_WDT-1:0] busRdData;
    logic                busAck;
    logic                busy;
    logic                errOverrun;
    logic                errTimeout;

    modport master (
        input  ssel, rxData, rxRdy, busRdData, busAck,
        output txData, txLoad, busAddr, busWrData, busWr, busRd, busy, errOverrun, errTimeout
    );

    modport slave (
        output ssel, rxData, rxRdy, busRdData, busAck,
        input  txData, txLoad, busAddr, busWrData, busWr, busRd, busy, errOverrun, errTimeout
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI byte stream to register bus sequencer: command byte, then write data or read stream.
// Define SPI_REG_CTRL_TIMEOUT_EN to abort bus requests not acknowledged within TIMEOUT_CYC.
module spi_reg_ctrl #(
    parameter int unsigned         DATA_WDT    = 8,
    parameter int unsigned         ADDR_WDT    = DATA_WDT - 1,
    parameter int unsigned         TIMEOUT_CYC = 16,
    parameter logic [DATA_WDT-1:0] FILL_BYTE   = 8'hFF
) (
    input logic            clk,
    input logic            reset,
    spi_reg_ctrl_if.master sif
);
    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StWrBus,
        StRdBus,
        StRdStream
    } state_e;

    state_e              state_q, state_d;
    logic                ssel_meta_q, ssel_sync_q, ssel_prev_q;
    logic [ADDR_WDT-1:0] addr_q, addr_d;
    logic [DATA_WDT-1:0] wr_data_q, wr_data_d;
    logic [DATA_WDT-1:0] tx_data_q, tx_data_d;
    logic                tx_load_q, tx_load_d;
    logic                bus_wr_q, bus_wr_d;
    logic                bus_rd_q, bus_rd_d;
    logic                err_ovr_q, err_ovr_d;
    logic                err_tmo_q, err_tmo_d;
    logic                frame_start, frame_end, expire;

    assign frame_start = ssel_prev_q & ~ssel_sync_q;
    assign frame_end   = ssel_sync_q;

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            in_bus;

    // Counter restarts on every entry to a bus state; ack on the expiry cycle still wins.
    assign in_bus = (state_q == StWrBus) || (state_q == StRdBus);
    assign tmo_d  = in_bus ? tmo_q + 1'b1 : '0;
    assign expire = in_bus && !sif.busAck && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_cfg;

    assign expire     = 1'b0;
    assign unused_cfg = (TIMEOUT_CYC != 0);
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        tx_data_d = tx_data_q;
        tx_load_d = 1'b0;
        bus_wr_d  = bus_wr_q;
        bus_rd_d  = bus_rd_q;
        err_ovr_d = err_ovr_q;
        err_tmo_d = err_tmo_q;

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    tx_data_d = '0;
                    tx_load_d = 1'b1;
                    err_ovr_d = 1'b0;
                    err_tmo_d = 1'b0;
                    state_d   = StCmd;
                end
            end
            StCmd: begin
                if (frame_end) begin
                    state_d = StIdle;
                end else if (sif.rxRdy) begin
                    addr_d = sif.rxData[ADDR_WDT-1:0];
                    if (sif.rxData[DATA_WDT-1]) begin
                        bus_rd_d = 1'b1;
                        state_d  = StRdBus;
                    end else begin
                        state_d = StWdata;
                    end
                end
            end
            StWdata: begin
                if (frame_end) begin
                    state_d = StIdle;
                end else if (sif.rxRdy) begin
                    wr_data_d = sif.rxData;
                    bus_wr_d  = 1'b1;
                    state_d   = StWrBus;
                end
            end
            StWrBus: begin
                if (sif.rxRdy) begin
                    err_ovr_d = 1'b1;
                end
                if (sif.busAck || expire) begin
                    bus_wr_d = 1'b0;
                    addr_d   = addr_q + 1'b1;
                    state_d  = frame_end ? StIdle : StWdata;
                    if (expire) begin
                        err_tmo_d = 1'b1;
                    end
                end
            end
            StRdBus: begin
                if (sif.rxRdy) begin
                    err_ovr_d = 1'b1;
                end
                if (sif.busAck || expire) begin
                    bus_rd_d = 1'b0;
                    addr_d   = addr_q + 1'b1;
                    if (expire) begin
                        err_tmo_d = 1'b1;
                    end
                    // A read finishing after ssel rose is dropped: nobody will shift it out.
                    if (frame_end) begin
                        state_d = StIdle;
                    end else begin
                        tx_data_d = expire ? FILL_BYTE : sif.busRdData;
                        tx_load_d = 1'b1;
                        state_d   = StRdStream;
                    end
                end
            end
            StRdStream: begin
                if (frame_end) begin
                    state_d = StIdle;
                end else if (sif.rxRdy) begin
                    bus_rd_d = 1'b1;
                    state_d  = StRdBus;
                end
            end
            default: begin
                bus_wr_d = 1'b0;
                bus_rd_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ssel_meta_q <= 1'b1;
            ssel_sync_q <= 1'b1;
            ssel_prev_q <= 1'b1;
            addr_q      <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            tx_load_q   <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            err_ovr_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ssel_meta_q <= sif.ssel;
            ssel_sync_q <= ssel_meta_q;
            ssel_prev_q <= ssel_sync_q;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
            tx_load_q   <= tx_load_d;
            bus_wr_q    <= bus_wr_d;
            bus_rd_q    <= bus_rd_d;
            err_ovr_q   <= err_ovr_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign sif.txData     = tx_data_q;
    assign sif.txLoad     = tx_load_q;
    assign sif.busAddr    = addr_q;
    assign sif.busWrData  = wr_data_q;
    assign sif.busWr      = bus_wr_q;
    assign sif.busRd      = bus_rd_q;
    assign sif.busy       = (state_q != StIdle);
    assign sif.errOverrun = err_ovr_q;
    assign sif.errTimeout = err_tmo_q;
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: stimulus queues expected bus cycles and MISO bytes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_spi_reg_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    spi_reg_ctrl_if #(.DATA_WDT(8), .ADDR_WDT(7)) sif ();

    spi_reg_ctrl #(
        .DATA_WDT   (8),
        .ADDR_WDT   (7),
        .TIMEOUT_CYC(16),
        .FILL_BYTE  (8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sif  (sif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    logic [7:0] mem [128];
    logic [6:0] exp_rd_addr[$];
    logic [6:0] exp_wr_addr[$];
    logic [7:0] exp_wr_data[$];
    logic [7:0] exp_tx[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h with nothing expected", name, act);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        sif.rxData = b;
        sif.rxRdy  = 1'b1;
        @(posedge clk);
        #1;
        sif.rxRdy = 1'b0;
    endtask

    task automatic frame_begin();
        exp_tx.push_back(8'h00);
        @(posedge clk);
        #1;
        sif.ssel = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic frame_finish();
        @(posedge clk);
        #1;
        sif.ssel = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    // Register bus model: acks the ack_delay+1'th request cycle, ack_delay<0 never acks.
    initial begin : responder
        int req_cnt;
        req_cnt       = 0;
        sif.busAck    = 1'b0;
        sif.busRdData = 8'hEE;
        forever begin
            @(posedge clk);
            #2;
            if (sif.busAck) begin
                sif.busAck    = 1'b0;
                sif.busRdData = 8'hEE;
                req_cnt       = 0;
            end else if (sif.busWr || sif.busRd) begin
                if (ack_delay >= 0 && req_cnt >= ack_delay) begin
                    sif.busAck    = 1'b1;
                    sif.busRdData = mem[sif.busAddr];
                end else begin
                    req_cnt++;
                end
            end else begin
                req_cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic prev_rd;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (sif.txLoad) begin
                    if (exp_tx.size() == 0) unexpected("tx_load", sif.txData);
                    else chk("tx_data", sif.txData, exp_tx.pop_front());
                end
                if (sif.busRd && !prev_rd) begin
                    if (exp_rd_addr.size() == 0) unexpected("bus_rd", sif.busAddr);
                    else chk("rd_addr", sif.busAddr, exp_rd_addr.pop_front());
                end
                if (sif.busWr && sif.busAck) begin
                    if (exp_wr_addr.size() == 0) begin
                        unexpected("bus_wr", sif.busWrData);
                    end else begin
                        chk("wr_addr", sif.busAddr, exp_wr_addr.pop_front());
                        chk("wr_data", sif.busWrData, exp_wr_data.pop_front());
                    end
                end
                if (sif.busWr && sif.busRd) unexpected("wr_and_rd", 1);
            end
            prev_rd = sif.busRd;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        sif.ssel   = 1'b1;
        sif.rxRdy  = 1'b0;
        sif.rxData = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        mem[2] = 8'h2B;
        mem[3] = 8'h3C;
        mem[4] = 8'h4D;
        mem[5] = 8'h5E;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", sif.busy, 0);
        chk("rst_bus_wr", sif.busWr, 0);
        chk("rst_bus_rd", sif.busRd, 0);
        chk("rst_tx_load", sif.txLoad, 0);
        chk("rst_tx_data", sif.txData, 0);
        chk("rst_err_ovr", sif.errOverrun, 0);
        chk("rst_err_tmo", sif.errTimeout, 0);
        reset = 1'b0;

        // Write burst with busy release timing.
        frame_begin();
        exp_wr_addr.push_back(7'h05); exp_wr_data.push_back(8'hA1);
        exp_wr_addr.push_back(7'h06); exp_wr_data.push_back(8'hB2);
        send_byte(8'h05, 4);
        send_byte(8'hA1, 8);
        send_byte(8'hB2, 8);
        repeat (8) @(posedge clk);
        #1;
        sif.ssel = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_sync", sif.busy, 1);
        @(posedge clk);
        #1;
        chk("busy_after_sync", sif.busy, 0);
        repeat (4) @(posedge clk);

        // Read burst: MISO 00,3C,4D then a third prefetch at addr 5.
        frame_begin();
        exp_rd_addr.push_back(7'h03);
        exp_rd_addr.push_back(7'h04);
        exp_rd_addr.push_back(7'h05);
        exp_tx.push_back(8'h3C);
        exp_tx.push_back(8'h4D);
        exp_tx.push_back(8'h5E);
        send_byte(8'h83, 4);
        send_byte(8'h00, 8);
        send_byte(8'h00, 8);
        repeat (8) @(posedge clk);
        frame_finish();

        // Address wrap.
        frame_begin();
        exp_wr_addr.push_back(7'h7F); exp_wr_data.push_back(8'h11);
        exp_wr_addr.push_back(7'h00); exp_wr_data.push_back(8'h22);
        send_byte(8'h7F, 4);
        send_byte(8'h11, 8);
        send_byte(8'h22, 8);
        repeat (8) @(posedge clk);
        frame_finish();

        // Frame end while a read waits 10 cycles for its ack.
        ack_delay = 10;
        frame_begin();
        exp_rd_addr.push_back(7'h02);
        send_byte(8'h82, 4);
        @(posedge clk);
        #1;
        sif.ssel = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("midrd_bus_rd_held", sif.busRd, 1);
        chk("midrd_busy_held", sif.busy, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("midrd_bus_rd_done", sif.busRd, 0);
        chk("midrd_idle", sif.busy, 0);
        chk("midrd_no_tx", exp_tx.size(), 0);

        // Overrun during a slow write.
        ack_delay = 12;
        frame_begin();
        exp_wr_addr.push_back(7'h10); exp_wr_data.push_back(8'h55);
        send_byte(8'h10, 4);
        send_byte(8'h55, 6);
        send_byte(8'h66, 3);
        chk("ovr_set", sif.errOverrun, 1);
        chk("ovr_bus_wr_held", sif.busWr, 1);
        repeat (15) @(posedge clk);
        frame_finish();
        chk("ovr_sticky", sif.errOverrun, 1);
        ack_delay = 0;
        frame_begin();
        chk("ovr_cleared", sif.errOverrun, 0);
        frame_finish();

`ifdef SPI_REG_CTRL_TIMEOUT_EN
        ack_delay = -1;
        frame_begin();
        exp_rd_addr.push_back(7'h00);
        exp_tx.push_back(8'hFF);
        send_byte(8'h80, 4);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (sif.busRd) n++;
            @(posedge clk);
            #1;
        end
        chk("tmo_req_cycles", n, 16);
        chk("tmo_err", sif.errTimeout, 1);
        frame_finish();
        ack_delay = 0;
`else
        n = 0;
        chk("tmo_tied_low", sif.errTimeout + n, 0);
`endif

        repeat (10) @(posedge clk);
        chk("end_tx_queue", exp_tx.size(), 0);
        chk("end_rd_queue", exp_rd_addr.size(), 0);
        chk("end_wr_queue", exp_wr_addr.size(), 0);
        chk("end_idle", sif.busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
